// File: rtl/add_mul_mix_pkg.sv
// Shared widths, FSM states and helpers for the
// add/multiply mix datapath and its inverse divider.
package add_mul_mix_pkg;

  localparam int W  = 4;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(PW) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Divisor is the wrapped sum; carry out is dropped.
  function automatic logic [W-1:0] sum_w(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/div_sub_mix_4_bit_restoring_div_step.sv
// One restoring-division iteration: shift in a dividend
// bit, subtract the divisor when it fits.
module restoring_div_step
  import add_mul_mix_pkg::*;
(
  input  logic [W-1:0] pr_i,
  input  logic         bit_i,
  input  logic [W-1:0] s_i,
  output logic [W-1:0] pr_o,
  output logic         q_o
);

  logic [W:0] trial;
  logic       ge;

  assign trial = {pr_i, bit_i};
  assign ge    = trial >= {1'b0, s_i};
  assign q_o   = ge;

  // After a restore the trial value is below S, so it fits W bits.
  assign pr_o  = ge ? W'(trial - {1'b0, s_i})
                    : trial[W-1:0];

endmodule

// File: rtl/div_sub_mix_4_bit.sv
// Bit-serial restoring divider: recovers Q = P / (c + d)
// with ready/valid on both sides, one request in flight.
module div_sub_mix_4_bit
  import add_mul_mix_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] prod,
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] quot,
  output logic [W-1:0]  rem,
  output logic          div_zero,
  output logic          exact
);

  state_e        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          exact_q, exact_d;

  logic [W-1:0]  sum;
  logic [W-1:0]  step_pr;
  logic          step_q;

  assign sum = sum_w(c, d);

  restoring_div_step u_step (
    .pr_i  (pr_q),
    .bit_i (p_q[PW-1]),
    .s_i   (s_q),
    .pr_o  (step_pr),
    .q_o   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      s_q     <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      s_q     <= s_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      exact_q <= exact_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    s_d     = s_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    exact_d = exact_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          p_d     = prod;
          s_d     = sum;
          rem_d   = '0;
          exact_d = 1'b0;
          dz_d    = (sum == '0);
          if (sum == '0) begin
            quot_d  = '1;
            state_d = DONE;
          end else begin
            quot_d  = '0;
            pr_d    = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d    = {p_q[PW-2:0], 1'b0};
        pr_d   = step_pr;
        quot_d = {quot_q[PW-2:0], step_q};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(PW - 1)) begin
          rem_d   = step_pr;
          exact_d = (step_pr == '0) &&
                    (quot_d[PW-1:W] == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign div_zero  = dz_q;
  assign exact     = exact_q;

endmodule

// File: tb/tb_div_sub_mix_4_bit.sv
// Directed plus random checks of the serial divider
// against a plain-arithmetic quotient/remainder model.
module tb_div_sub_mix_4_bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] prod;
  logic [3:0] c;
  logic [3:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quot;
  logic [3:0] rem;
  logic       div_zero;
  logic       exact;

  int n_cmp = 0;
  int n_err = 0;

  div_sub_mix_4_bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .div_zero  (div_zero),
    .exact     (exact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input logic [7:0] p,
                         input logic [3:0] ci,
                         input logic [3:0] di,
                         input int stall);
    int s, q, r, n;
    logic ex;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
    prod     = p;
    c        = ci;
    d        = di;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    prod     = 8'($urandom);
    c        = 4'($urandom);
    d        = 4'($urandom);
    s = (int'(ci) + int'(di)) % 16;
    if (s == 0) begin
      q = 255;
      r = 0;
    end else begin
      q = int'(p) / s;
      r = int'(p) % s;
    end
    ex = (s != 0) && (r == 0) && (q < 16);
    n = 1;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    chk("latency", 32'(n), (s == 0) ? 32'd1 : 32'd9);
    chk("quot", 32'(quot), 32'(q));
    chk("rem", 32'(rem), 32'(r));
    chk("div_zero", 32'(div_zero), 32'(s == 0));
    chk("exact", 32'(exact), 32'(ex));
    chk("busy_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_quot", 32'(quot), 32'(q));
      chk("hold_rem", 32'(rem), 32'(r));
      chk("hold_exact", 32'(exact), 32'(ex));
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] rc, rd;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    prod      = '0;
    c         = '0;
    d         = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    chk("rst_exact", 32'(exact), 32'd0);

    run_req(8'h2A, 4'd3, 4'd4, 5);
    run_req(8'hFF, 4'd0, 4'd1, 0);
    run_req(8'h2B, 4'd9, 4'd13, 0);
    run_req(8'h10, 4'd9, 4'd7, 2);

    prod     = 8'h2A;
    c        = 4'd3;
    d        = 4'd4;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_quot", 32'(quot), 32'd0);
    run_req(8'h31, 4'd5, 4'd2, 0);

    for (int k = 0; k < 24; k++) begin
      rc = 4'($urandom_range(0, 15));
      rd = 4'($urandom);
      if ($urandom_range(0, 3) == 0) rd = 4'(16 - int'(rc));
      run_req(8'($urandom), rc, rd,
              int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_sub_mix_4_bit.md
Name: div_sub_mix_4_bit

Overview:
- Inverse companion of the combinational add-then-multiply datapath: takes an 8-bit product P and the operand pair (c, d).
- Recovers the other factor Q = P / ((c + d) mod 2^W) and remainder R, using a bit-serial restoring divider.
- Flags whether P is an exact product of in-range factors.
- Sits on the checker/inverse path with ready/valid handshakes on both sides; one request in flight at a time.

Parameters:
- W, 4, operand width. Sum S = (c + d) mod 2^W; P and Q are 2W bits; R is W bits.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept request
- prod  in  2W  dividend P, bit 0 = LSB
- c  in  W  addend c
- d  in  W  addend d
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quot  out  2W  quotient Q
- rem  out  W  remainder R
- div_zero  out  1  S == 0
- exact  out  1  R == 0 and Q < 2^W and !div_zero

Behaviour:
- Reset values: in_ready=1 (first cycle after rst deasserts), out_valid=0, quot=0, rem=0, div_zero=0, exact=0, state=IDLE.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register P and S=(c+d) truncated to W bits; the carry out of the add is discarded.
  - If S==0, go to DONE with quot=all ones, rem=0, div_zero=1, exact=0.
  - Otherwise clear the partial remainder and iteration counter, then go to CALC.
- CALC:
  - in_ready=0. Exactly 2W iterations, one quotient bit per cycle, MSB first.
  - Each cycle: partial remainder pr (W+1 bits) = {pr[W-1:0], next dividend bit}. If pr >= S, pr -= S and the quotient bit is 1; otherwise the quotient bit is 0.
  - After the 2W-th iteration go to DONE; rem = pr[W-1:0].
  - Counter is ceil(log2(2W))+1 bits and does not wrap within one operation.
- DONE:
  - out_valid=1. quot, rem, div_zero and exact are stable and unchanged while out_valid && !out_ready.
  - On out_ready go to IDLE and drop out_valid the next cycle.
- Latency: accept at cycle T → out_valid at T+2W+1 (T+9 for W=4). For div-by-zero, out_valid at T+1.
- Throughput: one request per 2W+2 cycles minimum. A new request is accepted no earlier than the cycle after the output handshake.
- in_valid while in_ready=0 is ignored; upstream holds it, per the ready/valid contract.
- Inputs are sampled only at accept; later changes to prod/c/d have no effect on the current operation.
- Reset mid-operation (any state): next cycle is IDLE; out_valid=0; any pending result is dropped without handshake.
- Q may reach 2^(2W)-1 (S=1, P=0xFF). No saturation; exact=0 whenever Q >= 2^W.
- All arithmetic is unsigned.

Decomposition:
- Shared package add_mul_mix_pkg:
  - W default constant.
  - State enum {IDLE, CALC, DONE}.
  - Derived widths PW=2W and CW (counter width).
- One sub-module, restoring_div_step: purely combinational. Inputs pr, dividend bit, S; outputs next pr and quotient bit.
- Top-level holds the FSM, counter and registers.

Test Plan:
- prod=0x2A, c=3, d=4 (S=7) → out_valid 9 cycles after accept; quot=0x06, rem=0, exact=1, div_zero=0.
- prod=0xFF, c=0, d=1 (S=1) → quot=0xFF, rem=0, exact=0 (Q >= 16).
- prod=0x2B, c=9, d=13 (S=22 mod 16=6) → quot=0x07, rem=1, exact=0.
- c=9, d=7 (S=0), prod=0x10 → out_valid at T+1; quot=0xFF, rem=0, div_zero=1, exact=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs and out_valid stable, in_ready=0. Pulse out_ready → next cycle in_ready=1, out_valid=0. A back-to-back second request is accepted one cycle after the handshake.
- Assert rst during CALC iteration 3 → next cycle state=IDLE, out_valid=0, in_ready=1. Then a fresh request prod=0x31, c=5, d=2 → quot=0x07, rem=0, exact=1.
